batchnorm_seq_ctrl: RTL and testbench

Sequencer for the batch-normalisation datapath. Runs one batch through two phases:
- Accumulate: the statistics accumulator sees BATCH_SIZE samples.
- Apply: the same BATCH_SIZE samples pass through the normaliser.
The block drives the accumulator's clear, enable and stats-request strobes and the stream handshakes. It carries no data, only control.

---
 rtl/batchnorm_seq_ctrl_if.sv | 36 +++
 rtl/batchnorm_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_batchnorm_seq_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/batchnorm_seq_ctrl_if.sv
// Control bundle between the batch-norm sequencer and its datapath neighbours.
// master: the sequencer; slave: the accumulator/normaliser/stream side.
interface batchnorm_seq_ctrl_if #(
    parameter int CNT_W       = 8,
    parameter int BATCH_CNT_W = 8
);
    logic                   start;
    logic                   cont;
    logic                   abort;
    logic                   in_valid;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic                   acc_clr;
    logic                   acc_en;
    logic                   stats_req;
    logic                   stats_valid;
    logic                   norm_en;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [CNT_W-1:0]       sample_cnt;
    logic [BATCH_CNT_W-1:0] batch_cnt;

    modport master (
        input  start, cont, abort, in_valid, out_ready, stats_valid,
        output in_ready, out_valid, acc_clr, acc_en, stats_req, norm_en,
               busy, done, err, sample_cnt, batch_cnt
    );

    modport slave (
        output start, cont, abort, in_valid, out_ready, stats_valid,
        input  in_ready, out_valid, acc_clr, acc_en, stats_req, norm_en,
               busy, done, err, sample_cnt, batch_cnt
    );
endinterface

// File: rtl/batchnorm_seq_ctrl.sv
// Batch-normalisation sequencer: runs one batch through an accumulate phase
// (statistics gathering) and an apply phase (normalisation), control only.
// Optional macro BN_TIMEOUT_EN adds a stats-wait timeout with a sticky err.
module batchnorm_seq_ctrl #(
    parameter int BATCH_SIZE    = 10,
    parameter int CNT_W         = 8,
    parameter int BATCH_CNT_W   = 8,
    parameter int STATS_TIMEOUT = 64
) (
    input logic                  clk,
    input logic                  rst,
    batchnorm_seq_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        STATS,
        APPLY,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(BATCH_SIZE - 1);

    state_t                 state;
    logic [CNT_W-1:0]       sample_cnt;
    logic [BATCH_CNT_W-1:0] batch_cnt;
    logic                   acc_clr;
    logic                   stats_req;
    logic                   done;
    logic                   busy;

`ifdef BN_TIMEOUT_EN
    localparam int TW = $clog2(STATS_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(STATS_TIMEOUT - 1);

    logic [TW-1:0] stats_timer;
    logic          err;
    logic          timeout_hit;

    // Final timeout cycle with no stats_valid and no abort ends the batch.
    assign timeout_hit = (state == STATS) && !bus.stats_valid && !bus.abort
                         && (stats_timer == TIMER_LAST);

    // Stats-wait cycle counter, zero on every STATS entry; err is sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stats_timer <= '0;
            err         <= 1'b0;
        end else begin
            if (state != STATS) begin
                stats_timer <= '0;
            end else begin
                stats_timer <= stats_timer + 1'b1;
            end
            if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.err = err;
`else
    // STATS_TIMEOUT only matters when the timeout is built in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^STATS_TIMEOUT;
    assign bus.err = 1'b0;
`endif

    // Phase sequencing with registered strobes; abort overrides all but reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            batch_cnt  <= '0;
            acc_clr    <= 1'b0;
            stats_req  <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            acc_clr <= 1'b0;
            done    <= 1'b0;
            if (bus.abort && (state != IDLE)) begin
                state      <= IDLE;
                sample_cnt <= '0;
                acc_clr    <= 1'b1;
                stats_req  <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state   <= CLEAR;
                            acc_clr <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        sample_cnt <= '0;
                        state      <= ACCUM;
                    end
                    ACCUM: begin
                        if (bus.in_valid) begin
                            if (sample_cnt == LAST_SAMPLE) begin
                                sample_cnt <= '0;
                                state      <= STATS;
                                stats_req  <= 1'b1;
                            end else begin
                                sample_cnt <= sample_cnt + 1'b1;
                            end
                        end
                    end
                    STATS: begin
                        if (bus.stats_valid) begin
                            stats_req <= 1'b0;
                            state     <= APPLY;
                        end
`ifdef BN_TIMEOUT_EN
                        else if (timeout_hit) begin
                            stats_req <= 1'b0;
                            state     <= IDLE;
                            acc_clr   <= 1'b1;
                            busy      <= 1'b0;
                        end
`endif
                    end
                    APPLY: begin
                        if (bus.in_valid && bus.out_ready) begin
                            if (sample_cnt == LAST_SAMPLE) begin
                                sample_cnt <= '0;
                                state      <= DONE;
                            end else begin
                                sample_cnt <= sample_cnt + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        done      <= 1'b1;
                        batch_cnt <= batch_cnt + 1'b1;
                        if (bus.cont) begin
                            state   <= CLEAR;
                            acc_clr <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Stream handshakes and capture strobes follow the phase and handshakes.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.acc_en    = 1'b0;
        bus.norm_en   = 1'b0;
        case (state)
            ACCUM: begin
                bus.in_ready = 1'b1;
                bus.acc_en   = bus.in_valid;
            end
            APPLY: begin
                bus.in_ready  = bus.out_ready;
                bus.out_valid = bus.in_valid;
                bus.norm_en   = bus.in_valid & bus.out_ready;
            end
            default: begin
            end
        endcase
    end

    assign bus.sample_cnt = sample_cnt;
    assign bus.batch_cnt  = batch_cnt;
    assign bus.acc_clr    = acc_clr;
    assign bus.stats_req  = stats_req;
    assign bus.done       = done;
    assign bus.busy       = busy;

endmodule

// File: tb/tb_batchnorm_seq_ctrl.sv
// Self-checking bench for batchnorm_seq_ctrl with randomized stream bubbles.
// Honours BN_TIMEOUT_EN the same way as the design.
module tb_batchnorm_seq_ctrl;

    localparam int N     = 10;
    localparam int CNT_W = 8;
    localparam int BCW   = 2;
    localparam int TO    = 64;
    localparam int BMOD  = 1 << BCW;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    batchnorm_seq_ctrl_if #(.CNT_W(CNT_W), .BATCH_CNT_W(BCW)) bif ();

    batchnorm_seq_ctrl #(
        .BATCH_SIZE(N), .CNT_W(CNT_W), .BATCH_CNT_W(BCW), .STATS_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: batches completed since reset and the sticky error.
    int completed = 0;
    bit model_err = 1'b0;

    // Per-scenario observations.
    int cyc, n_acc, n_norm, n_done, n_clr, n_sreq, last_done_cyc, last_clr_cyc;
    int first_ready_cyc, max_cnt, stall_xfer, cnt_mis, idle_cycles, sreq_run;
    int stats_delay;
    bit bubbles, track_cnt, cont_level;

    task automatic clear_obs();
        n_acc = 0; n_norm = 0; n_done = 0; n_clr = 0; n_sreq = 0;
        last_done_cyc = -1; last_clr_cyc = -1; first_ready_cyc = -1;
        max_cnt = 0; stall_xfer = 0; cnt_mis = 0; idle_cycles = 0;
    endtask

    // One clock: drive inputs at the falling edge, observe 1 time unit later.
    task automatic step(input bit st, input bit ab, input bit ct);
        @(negedge clk);
        bif.start     = st;
        bif.abort     = ab;
        bif.cont      = ct;
        bif.in_valid  = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
        bif.out_ready = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bif.stats_req) sreq_run++; else sreq_run = 0;
        bif.stats_valid = (stats_delay >= 0) && (sreq_run > stats_delay);
        #1;
        cyc++;
        if (track_cnt && (int'(bif.sample_cnt) != (n_acc + n_norm) % N)) cnt_mis++;
        if (int'(bif.sample_cnt) > max_cnt) max_cnt = int'(bif.sample_cnt);
        if (bif.stats_req) n_sreq++;
        if (bif.stats_req && (bif.in_ready || bif.acc_en || bif.norm_en)) stall_xfer++;
        if (bif.in_ready && first_ready_cyc < 0) first_ready_cyc = cyc;
        if (!ab) begin
            if (bif.acc_en) n_acc++;
            if (bif.norm_en) n_norm++;
        end
        if (bif.done) begin n_done++; last_done_cyc = cyc; end
        if (bif.acc_clr) begin n_clr++; last_clr_cyc = cyc; end
        if (!bif.busy) idle_cycles++;
    endtask

    task automatic run_to_done(input int budget);
        int d0 = n_done;
        int b = 0;
        while (n_done == d0 && b < budget) begin
            step(1'b0, 1'b0, cont_level);
            b++;
        end
        checks++;
        if (n_done == d0) begin
            errors++;
            $display("[TB] FAIL done_wait: no done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.start = 0; bif.cont = 0; bif.abort = 0; bif.in_valid = 0;
        bif.out_ready = 0; bif.stats_valid = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bif.busy, bif.done, bif.err, bif.acc_clr, bif.stats_req, bif.in_ready,
             bif.out_valid, bif.acc_en, bif.norm_en} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got %b, expected 0",
                     {bif.busy, bif.done, bif.err, bif.acc_clr, bif.stats_req,
                      bif.in_ready, bif.out_valid, bif.acc_en, bif.norm_en});
        end
        checks++;
        if (bif.sample_cnt !== '0 || bif.batch_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counts: got %0d/%0d, expected 0/0",
                     bif.sample_cnt, bif.batch_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single batch without bubbles; stats come back after 'delay' extra cycles.
    task automatic test_basic(input int delay);
        int c0;
        bubbles = 0; track_cnt = 1; cont_level = 0; stats_delay = delay;
        clear_obs();
        step(1'b1, 1'b0, 1'b0);
        c0 = cyc;
        run_to_done(200);
        completed++;
        checks++;
        if (n_clr != 1 || last_clr_cyc != c0 + 1) begin
            errors++;
            $display("[TB] FAIL basic_acc_clr: got %0d pulses at %0d, expected 1 at %0d",
                     n_clr, last_clr_cyc - c0, 1);
        end
        checks++;
        if (first_ready_cyc != c0 + 2) begin
            errors++;
            $display("[TB] FAIL basic_ready_latency: got %0d, expected 2", first_ready_cyc - c0);
        end
        checks++;
        if (n_acc != N || n_norm != N) begin
            errors++;
            $display("[TB] FAIL basic_strobes: got acc=%0d norm=%0d, expected %0d each",
                     n_acc, n_norm, N);
        end
        checks++;
        if (last_done_cyc != c0 + 2 * N + 4 + delay) begin
            errors++;
            $display("[TB] FAIL basic_done_cycle: got %0d, expected %0d",
                     last_done_cyc - c0, 2 * N + 4 + delay);
        end
        checks++;
        if (int'(bif.batch_cnt) != completed % BMOD || cnt_mis != 0) begin
            errors++;
            $display("[TB] FAIL basic_counts: got batch_cnt=%0d cnt_mis=%0d, expected %0d/0",
                     bif.batch_cnt, cnt_mis, completed % BMOD);
        end
    endtask

    task automatic test_bubbles();
        for (int i = 0; i < 3; i++) begin
            bubbles = 1; track_cnt = 1; cont_level = 0;
            stats_delay = int'($urandom_range(0, 5));
            clear_obs();
            step(1'b1, 1'b0, 1'b0);
            run_to_done(600);
            completed++;
            checks++;
            if (n_acc != N || n_norm != N || n_done != 1) begin
                errors++;
                $display("[TB] FAIL bubbles_strobes: got acc=%0d norm=%0d done=%0d, expected %0d/%0d/1",
                         n_acc, n_norm, n_done, N, N);
            end
            checks++;
            if (max_cnt > N - 1 || stall_xfer != 0 || cnt_mis != 0) begin
                errors++;
                $display("[TB] FAIL bubbles_cnt: got max=%0d stats_xfer=%0d cnt_mis=%0d, expected <=%0d/0/0",
                         max_cnt, stall_xfer, cnt_mis, N - 1);
            end
            checks++;
            if (int'(bif.batch_cnt) != completed % BMOD) begin
                errors++;
                $display("[TB] FAIL bubbles_batch_cnt: got %0d, expected %0d",
                         bif.batch_cnt, completed % BMOD);
            end
        end
        bubbles = 0;
    endtask

    // Three batches chained with cont; DONE goes straight back to CLEAR.
    task automatic test_back_to_back();
        int c0;
        bubbles = 0; track_cnt = 1; stats_delay = 0; cont_level = 1;
        clear_obs();
        step(1'b1, 1'b0, 1'b1);
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) cont_level = 0;
            run_to_done(200);
            completed++;
        end
        checks++;
        if (n_done != 3 || n_clr != 3) begin
            errors++;
            $display("[TB] FAIL b2b_pulses: got done=%0d clr=%0d, expected 3/3", n_done, n_clr);
        end
        checks++;
        if (last_done_cyc != c0 + (2 * N + 4) + 2 * (2 * N + 3) || idle_cycles != 2) begin
            errors++;
            $display("[TB] FAIL b2b_timing: got done at %0d idle=%0d, expected %0d/2",
                     last_done_cyc - c0, idle_cycles, (2 * N + 4) + 2 * (2 * N + 3));
        end
        checks++;
        if (int'(bif.batch_cnt) != completed % BMOD) begin
            errors++;
            $display("[TB] FAIL b2b_batch_cnt: got %0d, expected %0d",
                     bif.batch_cnt, completed % BMOD);
        end
        cont_level = 0;
    endtask

    task automatic test_abort();
        int b = 0;
        bubbles = 0; track_cnt = 0; stats_delay = 1; cont_level = 0;
        clear_obs();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (bif.busy !== 1'b0 || bif.acc_clr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_idle: got busy=%b acc_clr=%b, expected 0/0",
                     bif.busy, bif.acc_clr);
        end
        step(1'b1, 1'b0, 1'b0);
        while (n_acc < 4 && b < 50) begin
            step(1'b0, 1'b0, 1'b0);
            b++;
        end
        step(1'b0, 1'b1, 1'b0);
        checks++;
        if (int'(bif.sample_cnt) != 4 || bif.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_pre: got cnt=%0d busy=%b, expected 4/1", bif.sample_cnt, bif.busy);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (bif.busy !== 1'b0 || bif.acc_clr !== 1'b1 || bif.sample_cnt !== '0 || n_done != 0) begin
            errors++;
            $display("[TB] FAIL abort_post: got busy=%b clr=%b cnt=%0d done=%0d, expected 0/1/0/0",
                     bif.busy, bif.acc_clr, bif.sample_cnt, n_done);
        end
        checks++;
        if (int'(bif.batch_cnt) != completed % BMOD) begin
            errors++;
            $display("[TB] FAIL abort_batch_cnt: got %0d, expected %0d", bif.batch_cnt, completed % BMOD);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (bif.acc_clr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_clr_width: got %b, expected 0", bif.acc_clr);
        end
        clear_obs();
        track_cnt = 1;
        step(1'b1, 1'b0, 1'b0);
        run_to_done(200);
        completed++;
        checks++;
        if (n_acc != N || n_norm != N || int'(bif.batch_cnt) != completed % BMOD) begin
            errors++;
            $display("[TB] FAIL abort_rerun: got acc=%0d norm=%0d bc=%0d, expected %0d/%0d/%0d",
                     n_acc, n_norm, bif.batch_cnt, N, N, completed % BMOD);
        end
    endtask

    task automatic test_timeout();
        int b = 0;
        bubbles = 0; track_cnt = 0; cont_level = 0; stats_delay = -1;
        clear_obs();
        step(1'b1, 1'b0, 1'b0);
`ifdef BN_TIMEOUT_EN
        while (!(n_sreq > 0 && !bif.busy) && b < 300) begin
            step(1'b0, 1'b0, 1'b0);
            b++;
        end
        model_err = 1'b1;
        checks++;
        if (n_sreq != TO || bif.busy !== 1'b0 || bif.acc_clr !== 1'b1 || n_done != 0) begin
            errors++;
            $display("[TB] FAIL timeout_exit: got stats=%0d busy=%b clr=%b done=%0d, expected %0d/0/1/0",
                     n_sreq, bif.busy, bif.acc_clr, n_done, TO);
        end
        checks++;
        if (bif.err !== model_err || int'(bif.batch_cnt) != completed % BMOD) begin
            errors++;
            $display("[TB] FAIL timeout_err: got err=%b bc=%0d, expected %b/%0d",
                     bif.err, bif.batch_cnt, model_err, completed % BMOD);
        end
        clear_obs();
        stats_delay = 2;
        step(1'b1, 1'b0, 1'b0);
        run_to_done(200);
        completed++;
        checks++;
        if (n_norm != N || bif.err !== model_err) begin
            errors++;
            $display("[TB] FAIL timeout_sticky: got norm=%0d err=%b, expected %0d/%b",
                     n_norm, bif.err, N, model_err);
        end
`else
        repeat (150) step(1'b0, 1'b0, 1'b0);
        checks++;
        if (bif.stats_req !== 1'b1 || bif.busy !== 1'b1 || bif.err !== model_err || n_done != 0) begin
            errors++;
            $display("[TB] FAIL stats_wait: got req=%b busy=%b err=%b done=%0d, expected 1/1/%b/0",
                     bif.stats_req, bif.busy, bif.err, n_done, model_err);
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (bif.busy !== 1'b0 || bif.stats_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stats_abort: got busy=%b req=%b, expected 0/0", bif.busy, bif.stats_req);
        end
`endif
    endtask

    task automatic test_async_reset();
        int b = 0;
        bubbles = 0; track_cnt = 0; cont_level = 0; stats_delay = 0;
        clear_obs();
        step(1'b1, 1'b0, 1'b0);
        while (n_norm < 3 && b < 100) begin
            step(1'b0, 1'b0, 1'b0);
            b++;
        end
        #2 rst = 1'b1;
        #1;
        completed = 0;
        model_err = 1'b0;
        checks++;
        if ({bif.busy, bif.done, bif.err, bif.acc_clr, bif.stats_req, bif.in_ready,
             bif.out_valid, bif.acc_en, bif.norm_en} !== 9'b0 ||
            bif.sample_cnt !== '0 || int'(bif.batch_cnt) != completed) begin
            errors++;
            $display("[TB] FAIL async_reset: got strobes=%b cnt=%0d bc=%0d, expected 0/0/0",
                     {bif.busy, bif.done, bif.err, bif.acc_clr, bif.stats_req,
                      bif.in_ready, bif.out_valid, bif.acc_en, bif.norm_en},
                     bif.sample_cnt, bif.batch_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (bif.busy !== 1'b1 || bif.acc_clr !== 1'b1 || bif.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_abort_clear: got busy=%b clr=%b rdy=%b, expected 1/1/0",
                     bif.busy, bif.acc_clr, bif.in_ready);
        end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (bif.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_abort_accum: got rdy=%b, expected 1", bif.in_ready);
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        cyc = 0; sreq_run = 0; stats_delay = 0;
        bubbles = 0; track_cnt = 0; cont_level = 0;
        clear_obs();
        test_reset();
        test_basic(3);
        test_basic(0);
        test_bubbles();
        test_back_to_back();
        test_abort();
        test_timeout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
